// File: rtl/alu_result_serializer.sv
// rtl/alu_result_serializer.sv - captures ALU results and streams them LSB-first as bytes (optional header via RES_SER_HDR_EN)
module alu_result_serializer #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [2*WIDTH-1:0]   Arith_OUT,
    input  logic                 Arith_Flag,
    input  logic                 TX_READY,
    input  logic                 Ovr_Clr,
    output logic [7:0]           TX_DATA,
    output logic                 TX_VALID,
    output logic                 Busy,
    output logic                 Overrun
);

    localparam int NBYTES = 2*WIDTH/8;
    localparam int CW     = $clog2(NBYTES+1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES-1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
`ifdef RES_SER_HDR_EN
    localparam logic [1:0] S_HDR    = 2'd2;
    localparam logic [1:0] S_START  = S_HDR;
    localparam logic [7:0] HDR_BYTE = 8'hA5;
`else
    localparam logic [1:0] S_START  = S_SEND;
`endif

    logic [1:0]         state;
    logic [2*WIDTH-1:0] shift_reg;
    logic [CW-1:0]      cnt;
    logic               handshake;
    logic               last_hs;
    logic               drop;

    assign handshake = TX_VALID && TX_READY;
    assign last_hs   = (state == S_SEND) && handshake && (cnt == LAST_CNT);
    // A result arriving while busy is lost unless it lands exactly on the
    // final byte handshake, where it is chained into a new frame.
    assign drop      = Arith_Flag && (state != S_IDLE) && !last_hs;

    assign TX_VALID = (state != S_IDLE);
    assign Busy     = (state != S_IDLE);
`ifdef RES_SER_HDR_EN
    assign TX_DATA  = (state == S_HDR) ? HDR_BYTE : shift_reg[7:0];
`else
    assign TX_DATA  = shift_reg[7:0];
`endif

    // Frame FSM: capture result, then shift one byte out per handshake
    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Arith_Flag) begin
                        shift_reg <= Arith_OUT;
                        cnt       <= '0;
                        state     <= S_START;
                    end
                end
`ifdef RES_SER_HDR_EN
                S_HDR: begin
                    if (handshake) begin
                        state <= S_SEND;
                    end
                end
`endif
                S_SEND: begin
                    if (handshake) begin
                        if (last_hs && Arith_Flag) begin
                            shift_reg <= Arith_OUT;
                            cnt       <= '0;
                            state     <= S_START;
                        end else begin
                            shift_reg <= shift_reg >> 8;
                            cnt       <= cnt + 1'b1;
                            if (last_hs) begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (RST) begin
            Overrun <= 1'b0;
        end else if (drop) begin
            Overrun <= 1'b1;
        end else if (Ovr_Clr) begin
            Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb/tb_alu_result_serializer.sv - scoreboard testbench for alu_result_serializer
module tb_alu_result_serializer;

`ifdef RES_SER_HDR_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic        clk = 1'b0;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Arith_Flag;
    logic        TX_READY;
    logic        Ovr_Clr;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        Busy;
    logic        Overrun;

    logic [7:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          hs_count = 0;

    alu_result_serializer #(.WIDTH(16)) dut (
        .clk(clk),
        .RST(RST),
        .Arith_OUT(Arith_OUT),
        .Arith_Flag(Arith_Flag),
        .TX_READY(TX_READY),
        .Ovr_Clr(Ovr_Clr),
        .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID),
        .Busy(Busy),
        .Overrun(Overrun)
    );

    always #5 clk = ~clk;

    // Scoreboard: every byte accepted downstream must match the queue head
    always @(negedge clk) begin
        logic [7:0] e;
        if (!RST && TX_VALID && TX_READY) begin
            hs_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte got=%02h expected=none", TX_DATA);
            end else begin
                e = exp_q.pop_front();
                if (TX_DATA !== e) begin
                    bad++;
                    $display("FAIL stream_byte got=%02h expected=%02h", TX_DATA, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input logic [31:0] r);
`ifdef RES_SER_HDR_EN
        exp_q.push_back(8'hA5);
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back(r[8*i +: 8]);
    endtask

    function automatic logic [7:0] first_byte(input logic [31:0] r);
`ifdef RES_SER_HDR_EN
        return 8'hA5;
`else
        return r[7:0];
`endif
    endfunction

    task automatic test_reset();
        RST = 1'b1; Arith_Flag = 1'b0; Arith_OUT = '0; TX_READY = 1'b0; Ovr_Clr = 1'b0;
        tick(); tick();
        total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b expected=0", TX_VALID); end
        total++; if (TX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data got=%02h expected=00", TX_DATA); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b expected=0", Busy); end
        total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b expected=0", Overrun); end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b expected=0", TX_VALID); end
        end
    endtask

    task automatic test_stream();
        int hs0;
        hs0 = hs_count;
        TX_READY = 1'b1;
        Arith_OUT = 32'h1234_5678; Arith_Flag = 1'b1; push_result(Arith_OUT);
        tick();
        Arith_Flag = 1'b0;
        total++; if (TX_VALID !== 1'b1 || TX_DATA !== first_byte(32'h1234_5678)) begin
            bad++; $display("FAIL stream_first got=%b/%02h expected=1/%02h", TX_VALID, TX_DATA, first_byte(32'h1234_5678));
        end
        for (int i = 0; i < FRAME-1; i++) tick();
        total++; if (Busy !== 1'b1 || TX_DATA !== 8'h12) begin bad++; $display("FAIL stream_last got=%b/%02h expected=1/12", Busy, TX_DATA); end
        tick();
        total++; if (Busy !== 1'b0 || TX_VALID !== 1'b0) begin bad++; $display("FAIL stream_done got=%b/%b expected=0/0", Busy, TX_VALID); end
        total++; if (hs_count - hs0 !== FRAME) begin bad++; $display("FAIL stream_count got=%0d expected=%0d", hs_count - hs0, FRAME); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stream_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        logic [7:0] prev;
        int hs0;
        int c;
        pat = 4'b1001;
        hs0 = hs_count;
        Arith_OUT = 32'h1234_5678; Arith_Flag = 1'b1; push_result(Arith_OUT);
        tick();
        Arith_Flag = 1'b0;
        c = 0;
        while (Busy && c < 40) begin
            TX_READY = pat[c % 4];
            prev = TX_DATA;
            tick();
            if (pat[c % 4] == 1'b0) begin
                total++;
                if (TX_VALID !== 1'b1 || TX_DATA !== prev) begin
                    bad++; $display("FAIL stall_hold got=%b/%02h expected=1/%02h", TX_VALID, TX_DATA, prev);
                end
            end
            c++;
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL stall_timeout got=%b expected=0", Busy); end
        total++; if (hs_count - hs0 !== FRAME) begin bad++; $display("FAIL stall_count got=%0d expected=%0d", hs_count - hs0, FRAME); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stall_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_overrun();
        int c;
        TX_READY = 1'b0;
        Arith_OUT = 32'h1234_5678; Arith_Flag = 1'b1; push_result(Arith_OUT);
        tick();
        Arith_OUT = 32'hDEAD_BEEF;
        tick();
        Arith_Flag = 1'b0;
        total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b expected=1", Overrun); end
        total++; if (TX_VALID !== 1'b1 || TX_DATA !== first_byte(32'h1234_5678)) begin
            bad++; $display("FAIL ovr_inflight got=%b/%02h expected=1/%02h", TX_VALID, TX_DATA, first_byte(32'h1234_5678));
        end
        Ovr_Clr = 1'b1; Arith_Flag = 1'b1;
        tick();
        Arith_Flag = 1'b0;
        total++; if (Overrun !== 1'b1) begin bad++; $display("FAIL ovr_set_wins got=%b expected=1", Overrun); end
        tick();
        Ovr_Clr = 1'b0;
        total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b expected=0", Overrun); end
        TX_READY = 1'b1;
        c = 0;
        while (Busy && c < 20) begin tick(); c++; end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b expected=0", Busy); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL ovr_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        TX_READY = 1'b1;
        Arith_OUT = 32'h1234_5678; Arith_Flag = 1'b1; push_result(Arith_OUT);
        tick();
        Arith_Flag = 1'b0;
        for (int i = 0; i < FRAME-1; i++) tick();
        Arith_OUT = 32'hCAFE_F00D; Arith_Flag = 1'b1; push_result(Arith_OUT);
        tick();
        Arith_Flag = 1'b0;
        total++; if (TX_VALID !== 1'b1 || TX_DATA !== first_byte(32'hCAFE_F00D)) begin
            bad++; $display("FAIL b2b_first got=%b/%02h expected=1/%02h", TX_VALID, TX_DATA, first_byte(32'hCAFE_F00D));
        end
        for (int i = 0; i < FRAME; i++) begin
            total++; if (TX_VALID !== 1'b1) begin bad++; $display("FAIL b2b_bubble got=%b expected=1 at=%0d", TX_VALID, i); end
            tick();
        end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b expected=0", Busy); end
        total++; if (Overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b expected=0", Overrun); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_left got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_mid_reset();
        TX_READY = 1'b1;
        Arith_OUT = 32'h0000_00FF; Arith_Flag = 1'b1; push_result(Arith_OUT);
        tick();
        Arith_Flag = 1'b0;
        tick(); tick();
        total++; if (exp_q.size() !== FRAME-2) begin bad++; $display("FAIL mid_progress got=%0d expected=%0d", exp_q.size(), FRAME-2); end
        TX_READY = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        total++; if (TX_VALID !== 1'b0 || Busy !== 1'b0 || TX_DATA !== 8'h00) begin
            bad++; $display("FAIL mid_reset got=%b/%b/%02h expected=0/0/00", TX_VALID, Busy, TX_DATA);
        end
        exp_q.delete();
        TX_READY = 1'b1;
        tick();
        total++; if (TX_VALID !== 1'b0) begin bad++; $display("FAIL mid_no_flush got=%b expected=0", TX_VALID); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
